// File: rtl/atcdmac300_arb_sched.sv
// Registered CH_NUM-channel scheduler: per-level round-robin, 1-cycle request-to-grant, grant held until ch_done.
// Offer waits on grant_ready (withdrawn if the request drops); optional aging via ATCDMAC300_ARB_AGING_EN.
module atcdmac300_arb_sched #(
   parameter int CH_NUM = 8,
   parameter int CH_IDW = 3,
   parameter int PRI_W  = 2,
   parameter int AGE_W  = 4
) (
   input  logic                      hclk,
   input  logic                      hresetn,
   input  logic                      arb_en,
   input  logic [CH_NUM-1:0]         ch_request,
   input  logic [CH_NUM*PRI_W-1:0]   ch_level,
   output logic                      grant_valid,
   input  logic                      grant_ready,
   output logic [CH_IDW-1:0]         grant_channel,
   output logic [PRI_W-1:0]          grant_level,
   input  logic                      ch_done,
   output logic                      arb_busy
);

   localparam int NLVL = 1 << PRI_W;
   localparam logic [PRI_W-1:0] LVL_MAX = {PRI_W{1'b1}};
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] OFFER = 2'd1;
   localparam logic [1:0] BUSY  = 2'd2;

   logic [1:0]        state;
   logic [CH_IDW-1:0] rr_ptr [NLVL];
   logic [PRI_W-1:0]  eff_lvl [CH_NUM];
   logic [PRI_W-1:0]  top_lvl;
   logic [CH_IDW-1:0] ptr;
   logic [CH_IDW-1:0] win_hi;
   logic [CH_IDW-1:0] win_lo;
   logic [CH_IDW-1:0] win_ch;
   logic              hi_found;
   logic              accept;

   assign accept   = (state == OFFER) && grant_ready;
   assign arb_busy = (state != IDLE);

`ifdef ATCDMAC300_ARB_AGING_EN
   logic [AGE_W-1:0] age [CH_NUM];

   always_comb begin
      for (int i = 0; i < CH_NUM; i++)
         eff_lvl[i] = (&age[i]) ? LVL_MAX : ch_level[i*PRI_W +: PRI_W];
   end

   // Starved channels only count up when a strictly higher level wins.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         for (int i = 0; i < CH_NUM; i++) age[i] <= '0;
      end else begin
         for (int i = 0; i < CH_NUM; i++) begin
            if (!ch_request[i])
               age[i] <= '0;
            else if (accept) begin
               if (CH_IDW'(i) == grant_channel)
                  age[i] <= '0;
               else if ((ch_level[i*PRI_W +: PRI_W] < grant_level) && !(&age[i]))
                  age[i] <= age[i] + 1'b1;
            end
         end
      end
   end
`else
   always_comb begin
      for (int i = 0; i < CH_NUM; i++)
         eff_lvl[i] = ch_level[i*PRI_W +: PRI_W];
   end
`endif

   // Wrapping scan: lowest candidate above the pointer, else lowest candidate overall.
   always_comb begin
      top_lvl  = '0;
      hi_found = 1'b0;
      win_hi   = '0;
      win_lo   = '0;
      for (int i = 0; i < CH_NUM; i++)
         if (ch_request[i] && (eff_lvl[i] > top_lvl)) top_lvl = eff_lvl[i];
      ptr = rr_ptr[top_lvl];
      for (int i = CH_NUM-1; i >= 0; i--) begin
         if (ch_request[i] && (eff_lvl[i] == top_lvl)) begin
            win_lo = CH_IDW'(i);
            if (CH_IDW'(i) > ptr) begin
               win_hi   = CH_IDW'(i);
               hi_found = 1'b1;
            end
         end
      end
      win_ch = hi_found ? win_hi : win_lo;
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state         <= IDLE;
         grant_valid   <= 1'b0;
         grant_channel <= '0;
         grant_level   <= '0;
         for (int l = 0; l < NLVL; l++) rr_ptr[l] <= CH_IDW'(CH_NUM-1);
      end else begin
         case (state)
            IDLE: begin
               if (arb_en && (|ch_request)) begin
                  grant_channel <= win_ch;
                  grant_level   <= top_lvl;
                  grant_valid   <= 1'b1;
                  state         <= OFFER;
               end
            end
            OFFER: begin
               if (grant_ready) begin
                  grant_valid          <= 1'b0;
                  rr_ptr[grant_level]  <= grant_channel;
                  state                <= BUSY;
               end else if (!ch_request[grant_channel]) begin
                  grant_valid <= 1'b0;
                  state       <= IDLE;
               end
            end
            BUSY: begin
               if (ch_done) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_atcdmac300_arb_sched.sv
// Directed bench for atcdmac300_arb_sched: an 8-channel and a 5-channel instance share clock and reset.
module tb_atcdmac300_arb_sched;

   logic        hclk;
   logic        hresetn;

   logic        arb_en_a, rdy_a, done_a, gv_a, busy_a;
   logic [7:0]  req_a;
   logic [15:0] lvl_a;
   logic [2:0]  gch_a;
   logic [1:0]  glv_a;

   logic        arb_en_b, rdy_b, done_b, gv_b, busy_b;
   logic [4:0]  req_b;
   logic [9:0]  lvl_b;
   logic [2:0]  gch_b;
   logic [1:0]  glv_b;

   int n_assert = 0;
   int n_fail   = 0;

   atcdmac300_arb_sched #(.CH_NUM(8), .CH_IDW(3), .PRI_W(2), .AGE_W(2)) dut_a (
      .hclk(hclk), .hresetn(hresetn), .arb_en(arb_en_a), .ch_request(req_a),
      .ch_level(lvl_a), .grant_valid(gv_a), .grant_ready(rdy_a),
      .grant_channel(gch_a), .grant_level(glv_a), .ch_done(done_a), .arb_busy(busy_a)
   );

   atcdmac300_arb_sched #(.CH_NUM(5), .CH_IDW(3), .PRI_W(2), .AGE_W(2)) dut_b (
      .hclk(hclk), .hresetn(hresetn), .arb_en(arb_en_b), .ch_request(req_b),
      .ch_level(lvl_b), .grant_valid(gv_b), .grant_ready(rdy_b),
      .grant_channel(gch_b), .grant_level(glv_b), .ch_done(done_b), .arb_busy(busy_b)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bounded wait for an offer on the selected instance, sampled on negedges.
   task automatic wait_vld(input bit b, input string tag);
      int n = 0;
      while (((b ? gv_b : gv_a) !== 1'b1) && (n < 20)) begin
         @(negedge hclk);
         n++;
      end
      check({tag, "_vld"}, b ? gv_b : gv_a, 1);
   endtask

   // One full grant with grant_ready high: offer, accept, done two cycles later, bubble.
   task automatic grant_cycle(input bit b, input int exp_ch, input int exp_lvl, input string tag);
      wait_vld(b, tag);
      check({tag, "_ch"},  b ? gch_b : gch_a, exp_ch);
      check({tag, "_lvl"}, b ? glv_b : glv_a, exp_lvl);
      @(negedge hclk);
      check({tag, "_busy"}, b ? busy_b : busy_a, 1);
      check({tag, "_vld_off"}, b ? gv_b : gv_a, 0);
      @(negedge hclk);
      if (b) done_b = 1'b1; else done_a = 1'b1;
      @(negedge hclk);
      done_a = 1'b0;
      done_b = 1'b0;
      check({tag, "_bubble_vld"}, b ? gv_b : gv_a, 0);
      check({tag, "_bubble_busy"}, b ? busy_b : busy_a, 0);
   endtask

   initial begin
      hresetn  = 1'b0;
      arb_en_a = 1'b0; rdy_a = 1'b0; done_a = 1'b0; req_a = '0; lvl_a = '0;
      arb_en_b = 1'b0; rdy_b = 1'b0; done_b = 1'b0; req_b = '0; lvl_b = '0;
      repeat (2) @(negedge hclk);
      check("rst_vld_a", gv_a, 0);
      check("rst_ch_a", gch_a, 0);
      check("rst_lvl_a", glv_a, 0);
      check("rst_busy_a", busy_a, 0);
      check("rst_vld_b", gv_b, 0);
      check("rst_busy_b", busy_b, 0);

      // All channels at level 0: strict rotation from the reset pointer
      @(negedge hclk);
      hresetn  = 1'b1;
      arb_en_a = 1'b1;
      rdy_a    = 1'b1;
      req_a    = 8'hFF;
      for (int k = 0; k < 9; k++) grant_cycle(0, k % 8, 0, "rr8");

      // Channel 3 at level 3 dominates channel 5 at level 0
      req_a = 8'h28;
      lvl_a = '0;
      lvl_a[7:6] = 2'd3;
      repeat (3) grant_cycle(0, 3, 3, "prio");

      // Stalled offer, arb_en dropped, then request withdrawn
      rdy_a = 1'b0;
      req_a = 8'h03;
      lvl_a = '0;
      wait_vld(0, "stall");
      check("stall_ch", gch_a, 1);
      arb_en_a = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge hclk);
         check("hold_vld", gv_a, 1);
         check("hold_ch", gch_a, 1);
         check("hold_lvl", glv_a, 0);
      end
      req_a    = 8'h04;
      arb_en_a = 1'b1;
      @(negedge hclk);
      check("drop_vld", gv_a, 0);
      check("drop_busy", busy_a, 0);
      req_a = 8'h06;
      wait_vld(0, "reoffer");
      check("reoffer_ch", gch_a, 1);

      // Ready and withdrawal in the same cycle: accepted
      rdy_a = 1'b1;
      req_a = 8'h04;
      @(negedge hclk);
      check("race_busy", busy_a, 1);
      check("race_vld", gv_a, 0);
      @(negedge hclk);
      done_a = 1'b1;
      @(negedge hclk);
      done_a = 1'b0;

      // Reset while busy on channel 6
      req_a = 8'h40;
      wait_vld(0, "ch6");
      check("ch6_ch", gch_a, 6);
      @(negedge hclk);
      check("ch6_busy", busy_a, 1);
      hresetn = 1'b0;
      #1;
      check("midrst_busy", busy_a, 0);
      check("midrst_vld", gv_a, 0);
      check("midrst_ch", gch_a, 0);
      @(negedge hclk);
      hresetn = 1'b1;
      req_a   = 8'h48;
      grant_cycle(0, 3, 0, "post_rst");

      // Channel 1 at level 0 against channel 2 at level 1
      req_a = 8'h06;
      lvl_a = '0;
      lvl_a[5:4] = 2'd1;
      repeat (3) grant_cycle(0, 2, 1, "age_pre");
`ifdef ATCDMAC300_ARB_AGING_EN
      grant_cycle(0, 1, 3, "aged");
`else
      grant_cycle(0, 2, 1, "no_age");
`endif
      arb_en_a = 1'b0;
      req_a    = '0;

      // Five-channel instance: wrap from pointer 4 skips unused codes
      arb_en_b = 1'b1;
      rdy_b    = 1'b1;
      req_b    = 5'b10001;
      grant_cycle(1, 0, 0, "ch5_first");
      grant_cycle(1, 4, 0, "ch5_second");
      grant_cycle(1, 0, 0, "ch5_third");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
